fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode Controller.
- Holds the PC and issues one outstanding read at a time to instruction memory over a req/ready + rvalid handshake.
- Registers the returned word into a single-entry output buffer and exposes opcode/funct3/funct7 slices to decode.
- Accepts a one-cycle redirect (taken branch / jal, driven from PCSrc plus the computed target) that flushes the buffer and kills any in-flight response.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, single-entry output buffer; instr_valid 1 cycle after rvalid.
// Requests only when the buffer is empty or draining; redirect flushes the buffer and kills in-flight data.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          r_state;
    logic            r_run;
    logic            r_kill;
    logic [XLEN-1:0] r_pc;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;

    logic            w_fire;
    logic            w_load;
    logic            w_consume;
    logic [XLEN-1:0] w_target;

    // r_run holds the request low until the first edge after reset release.
    assign imem_req  = r_run && (r_state == S_FETCH) && (!r_instr_valid || instr_ready);
    assign imem_addr = r_pc;

    assign w_fire    = imem_req && imem_ready;
    assign w_load    = (r_state == S_WAIT) && imem_rvalid && !r_kill && !redirect_valid;
    assign w_consume = r_instr_valid && instr_ready;
    assign w_target  = redirect_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_run         <= 1'b0;
            r_kill        <= 1'b0;
            r_pc          <= RESET_PC & ALIGN_MASK;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_run <= 1'b1;

            case (r_state)
                S_FETCH: begin
                    if (w_fire) begin
                        r_state <= S_WAIT;
                        r_kill  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                        r_kill  <= 1'b0;
                    end else if (redirect_valid) begin
                        r_kill  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase

            // Redirect beats both a same-cycle response and a consume.
            if (redirect_valid) begin
                r_instr_valid <= 1'b0;
            end else if (w_load) begin
                r_instr_valid <= 1'b1;
            end else if (w_consume) begin
                r_instr_valid <= 1'b0;
            end

            if (w_load) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end

            if (redirect_valid) begin
                r_pc <= w_target;
            end else if (w_load) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[6:0];
    assign funct3      = r_instr[14:12];
    assign funct7      = r_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one task per scenario, hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7)
    );

    always #5 clk = ~clk;

    // Return 1 time unit after a rising edge; inputs are then set and checks made 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
        step(); step();
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", instr); end
        rst_n = 1'b1;
        step();
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %0b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL wait_req: got %0b want 0", imem_req); end
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %0b want 1", instr_valid); end
        tests++; if (instr !== 32'h0050_0093) begin fails++; $display("FAIL first_instr: got %h want 00500093", instr); end
        tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL first_pc: got %h want 0", instr_pc); end
        tests++; if (opcode !== 7'h13) begin fails++; $display("FAIL first_opcode: got %h want 13", opcode); end
        tests++; if (funct3 !== 3'h0) begin fails++; $display("FAIL first_funct3: got %h want 0", funct3); end
        tests++; if (funct7 !== 7'h0) begin fails++; $display("FAIL first_funct7: got %h want 0", funct7); end
        tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL next_addr: got %h want 4", imem_addr); end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin fails++; $display("FAIL drain_req: got req=%0b addr=%h want req=1 addr=4", imem_req, imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0; instr_ready = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin fails++; $display("FAIL second_load: got valid=%0b pc=%h want valid=1 pc=4", instr_valid, instr_pc); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req[%0d]: got %0b want 0", i, imem_req); end
            tests++; if (instr !== 32'h00A0_0113 || instr_valid !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d]: got %h/%0b want 00a00113/1", i, instr, instr_valid); end
            step();
            #1;
        end
        instr_ready = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin fails++; $display("FAIL bp_release: got req=%0b addr=%h want req=1 addr=8", imem_req, imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h4000_0033;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (funct7 !== 7'h20 || opcode !== 7'h33 || instr_pc !== 32'h8) begin fails++; $display("FAIL sub_decode: got f7=%h op=%h pc=%h want 20/33/8", funct7, opcode, instr_pc); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin fails++; $display("FAIL back_to_back: got req=%0b addr=%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_imem_stall();
        int nfires = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin fails++; $display("FAIL stall[%0d]: got req=%0b addr=%h want 1/c", i, imem_req, imem_addr); end
            if (imem_req && imem_ready) nfires++;
            step();
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (imem_req && imem_ready) nfires++;
            step();
        end
        tests++; if (nfires !== 1) begin fails++; $display("FAIL stall_fires: got %0d want 1", nfires); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin fails++; $display("FAIL stall_load: got valid=%0b pc=%h want 1/c", instr_valid, instr_pc); end
    endtask

    task automatic test_redirect_wait();
        step();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_req: got %0b want 0", imem_req); end
        step();
        redirect_valid = 1'b0;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin fails++; $display("FAIL rw_drop: got valid=%0b instr=%h want 0/00000013", instr_valid, instr); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rw_addr: got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_rvalid();
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h00C0_0193;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin fails++; $display("FAIL rr_load: got valid=%0b pc=%h want 1/100", instr_valid, instr_pc); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
        step();
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || instr !== 32'h00C0_0193) begin fails++; $display("FAIL rr_drop: got valid=%0b instr=%h want 0/00c00193", instr_valid, instr); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL rr_addr: got req=%0b addr=%h want 1/200", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_fetch();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h300) begin fails++; $display("FAIL rf_wait: got req=%0b addr=%h want 0/300", imem_req, imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin fails++; $display("FAIL rf_kill: got valid=%0b req=%0b addr=%h want 0/1/300", instr_valid, imem_req, imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
        step();
        imem_rvalid = 1'b0; imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0400;
        #1;
        tests++; if (instr_valid !== 1'b1 || opcode !== 7'h73 || instr_pc !== 32'h300) begin fails++; $display("FAIL rf_load: got valid=%0b op=%h pc=%h want 1/73/300", instr_valid, opcode, instr_pc); end
        step();
        redirect_valid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin fails++; $display("FAIL rf_flush: got valid=%0b req=%0b addr=%h want 0/1/400", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        #1;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hFE00_7FA3;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_pc: got pc=%h addr=%h want fffffffc/0", instr_pc, imem_addr); end
        tests++; if (opcode !== 7'h23 || funct3 !== 3'h7 || funct7 !== 7'h7F) begin fails++; $display("FAIL wrap_decode: got %h/%h/%h want 23/7/7f", opcode, funct3, funct7); end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
        step();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL mid_rst_clear: got %0b/%h/%h want 0/0/0", instr_valid, instr, instr_pc); end
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL mid_rst_req: got req=%0b addr=%h want 0/0", imem_req, imem_addr); end
        step();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL stale_ignored: got valid=%0b req=%0b addr=%h want 0/1/0", instr_valid, imem_req, imem_addr); end
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0050_0093) begin fails++; $display("FAIL restart: got valid=%0b pc=%h instr=%h want 1/0/00500093", instr_valid, instr_pc, instr); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_imem_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_fetch();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
